// File: rtl/ecc_reg_scrubber.sv
// Background SEC-DED scrubber for the register file: periodically reads one register, checks it,
// and writes back corrected data/parity through an arbitrated port. Double errors are only logged.
module ecc_reg_scrubber #(
    parameter int unsigned INTERVAL   = 1024,
    parameter int unsigned FIRST_ADDR = 1,
    parameter int unsigned LAST_ADDR  = 31,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             scrub_en,
    input  logic             clear_stats,
    output logic [4:0]       rd_addr,
    input  logic [31:0]      rd_data,
    input  logic [14:0]      rd_parity,
    input  logic             cpu_we,
    input  logic [4:0]       cpu_waddr,
    output logic             wb_req,
    input  logic             wb_gnt,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic [14:0]      wb_parity,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count,
    output logic             uncorr_flag,
    output logic [4:0]       uncorr_addr,
    output logic             busy
);

    localparam int unsigned WaitW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [WaitW-1:0] WaitLoad = WaitW'(INTERVAL - 1);
    localparam logic [4:0] FirstA = 5'(FIRST_ADDR);
    localparam logic [4:0] LastA  = 5'(LAST_ADDR);

    // Hsiao-style H matrix: data bit i uses the i-th weight-3 column in lexicographic order,
    // parity bits are unit columns, so every single-bit syndrome is distinct and odd.
    function automatic logic [479:0] gen_cols();
        logic [479:0] r;
        int n;
        r = '0;
        n = 0;
        for (int a = 0; a < 15; a++) begin
            for (int b = a + 1; b < 15; b++) begin
                for (int c = b + 1; c < 15; c++) begin
                    if (n < 32) begin
                        r[n*15 +: 15] = (15'(1) << a) | (15'(1) << b) | (15'(1) << c);
                        n++;
                    end
                end
            end
        end
        return r;
    endfunction

    localparam logic [479:0] HCols = gen_cols();

    function automatic logic [14:0] encode(input logic [31:0] d);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) p = p ^ HCols[i*15 +: 15];
        end
        return p;
    endfunction

    typedef enum logic [2:0] {StIdle, StWait, StRead, StCheck, StWb} state_e;

    state_e           state_q, state_d;
    logic [4:0]       addr_q, addr_d;
    logic [WaitW-1:0] wcnt_q, wcnt_d;
    logic [31:0]      cap_data_q, cap_data_d;
    logic [14:0]      cap_par_q, cap_par_d;
    logic             wb_req_q, wb_req_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [14:0]      wb_par_q, wb_par_d;
    logic [CNT_W-1:0] corr_q, corr_d, uncorr_q, uncorr_d;
    logic             uflag_q, uflag_d;
    logic [4:0]       uaddr_q, uaddr_d;

    logic [14:0] syn, enc_corr;
    logic [31:0] corrected;
    logic        hit, dbl_err, sgl_err, conflict, corr_inc, unc_inc;
    logic [4:0]  next_addr;

    always_comb begin
        syn       = encode(cap_data_q) ^ cap_par_q;
        corrected = cap_data_q;
        hit       = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (syn == HCols[i*15 +: 15]) begin
                corrected[i] = ~cap_data_q[i];
                hit          = 1'b1;
            end
        end
        enc_corr = encode(corrected);
        dbl_err  = (syn != '0) && !hit && !$onehot(syn);
        sgl_err  = !dbl_err && ((corrected != cap_data_q) || (enc_corr != cap_par_q));
    end

    assign conflict  = cpu_we && (cpu_waddr == addr_q);
    assign next_addr = (addr_q == LastA) ? FirstA : addr_q + 5'd1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        cap_data_d = cap_data_q;
        cap_par_d  = cap_par_q;
        wb_req_d   = wb_req_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_par_d   = wb_par_q;
        uaddr_d    = uaddr_q;
        corr_inc   = 1'b0;
        unc_inc    = 1'b0;

        if (!scrub_en) begin
            state_d  = StIdle;
            wb_req_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWait;
                    wcnt_d  = WaitLoad;
                end
                StWait: begin
                    if (wcnt_q == '0) state_d = StRead;
                    else              wcnt_d  = wcnt_q - 1'b1;
                end
                StRead: begin
                    cap_data_d = rd_data;
                    cap_par_d  = rd_parity;
                    state_d    = StCheck;
                    if (conflict) begin
                        state_d = StWait;
                        wcnt_d  = WaitLoad;
                        addr_d  = next_addr;
                    end
                end
                StCheck: begin
                    if (dbl_err) begin
                        unc_inc = 1'b1;
                        uaddr_d = addr_q;
                    end else if (sgl_err) begin
                        corr_inc  = 1'b1;
                        wb_addr_d = addr_q;
                        wb_data_d = corrected;
                        wb_par_d  = enc_corr;
                    end
                    if (sgl_err && !conflict) begin
                        state_d  = StWb;
                        wb_req_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        wcnt_d  = WaitLoad;
                        addr_d  = next_addr;
                    end
                end
                StWb: begin
                    if (conflict || wb_gnt) begin
                        state_d  = StWait;
                        wcnt_d   = WaitLoad;
                        addr_d   = next_addr;
                        wb_req_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        uflag_d  = uflag_q;
        if (clear_stats) begin
            corr_d   = '0;
            uncorr_d = '0;
            uflag_d  = 1'b0;
            uaddr_d  = '0;
        end else begin
            if (corr_inc && (corr_q != '1)) corr_d = corr_q + 1'b1;
            if (unc_inc) begin
                uflag_d = 1'b1;
                if (uncorr_q != '1) uncorr_d = uncorr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= StIdle;
            addr_q     <= FirstA;
            wcnt_q     <= WaitLoad;
            cap_data_q <= '0;
            cap_par_q  <= '0;
            wb_req_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_par_q   <= '0;
            corr_q     <= '0;
            uncorr_q   <= '0;
            uflag_q    <= 1'b0;
            uaddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            cap_data_q <= cap_data_d;
            cap_par_q  <= cap_par_d;
            wb_req_q   <= wb_req_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_par_q   <= wb_par_d;
            corr_q     <= corr_d;
            uncorr_q   <= uncorr_d;
            uflag_q    <= uflag_d;
            uaddr_q    <= uaddr_d;
        end
    end

    assign rd_addr      = addr_q;
    assign wb_req       = wb_req_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign wb_parity    = wb_par_q;
    assign corr_count   = corr_q;
    assign uncorr_count = uncorr_q;
    assign uncorr_flag  = uflag_q;
    assign uncorr_addr  = uaddr_q;
    assign busy         = (state_q == StRead) || (state_q == StCheck) || (state_q == StWb);

endmodule

// File: tb/tb_ecc_reg_scrubber.sv
// Self-checking bench for ecc_reg_scrubber: behavioural register file, scoreboard of expected
// writebacks, and one task per scenario.
module tb_ecc_reg_scrubber;
    localparam int unsigned INTERVAL = 4;
    localparam int unsigned CNT_W    = 16;

    logic clk = 1'b0, rstN = 1'b0, scrub_en = 1'b0, clear_stats = 1'b0, cpu_we = 1'b0;
    logic [4:0] cpu_waddr = '0;
    logic man_gnt = 1'b0, auto_gnt = 1'b0;
    logic [4:0] rd_addr, wb_addr, uncorr_addr;
    logic [31:0] rd_data, wb_data;
    logic [14:0] rd_parity, wb_parity;
    logic wb_req, wb_gnt, uncorr_flag, busy;
    logic [CNT_W-1:0] corr_count, uncorr_count;

    logic [31:0] mem_d [32];
    logic [14:0] mem_p [32];
    logic [14:0] hcol [32];

    logic [4:0]  chk_addr [$];
    int          chk_cyc [$];
    logic [51:0] obs_wb [$];
    logic [51:0] exp_wb [$];
    int cyc = 0, wbreq_cycles = 0, n_checks = 0, n_fail = 0;
    bit busy_prev = 1'b0;

    assign rd_data   = mem_d[rd_addr];
    assign rd_parity = mem_p[rd_addr];
    assign wb_gnt    = auto_gnt ? wb_req : man_gnt;

    ecc_reg_scrubber #(.INTERVAL(INTERVAL), .FIRST_ADDR(1), .LAST_ADDR(31), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstN(rstN), .scrub_en(scrub_en), .clear_stats(clear_stats),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_parity(rd_parity),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr),
        .wb_req(wb_req), .wb_gnt(wb_gnt), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_parity(wb_parity), .corr_count(corr_count), .uncorr_count(uncorr_count),
        .uncorr_flag(uncorr_flag), .uncorr_addr(uncorr_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (busy && !busy_prev) begin
            chk_addr.push_back(rd_addr);
            chk_cyc.push_back(cyc);
        end
        busy_prev = busy;
        if (wb_req) wbreq_cycles++;
        if (wb_req && wb_gnt) obs_wb.push_back({wb_addr, wb_data, wb_parity});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Column table built by stepping a (a,b,c) triple counter.
    task automatic build_cols();
        int a = 0, b = 1, c = 2;
        for (int i = 0; i < 32; i++) begin
            hcol[i] = '0;
            hcol[i][a] = 1'b1;
            hcol[i][b] = 1'b1;
            hcol[i][c] = 1'b1;
            c++;
            if (c == 15) begin
                b++;
                c = b + 1;
                if (c == 15) begin
                    a++;
                    b = a + 1;
                    c = b + 1;
                end
            end
        end
    endtask

    function automatic logic [14:0] enc(input logic [31:0] d);
        logic [14:0] p = '0;
        for (int j = 0; j < 32; j++) if (d[j]) p = p ^ hcol[j];
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_clean();
        for (int i = 0; i < 32; i++) begin
            mem_d[i] = $urandom;
            mem_p[i] = enc(mem_d[i]);
        end
    endtask

    task automatic do_reset();
        scrub_en = 1'b0; clear_stats = 1'b0; cpu_we = 1'b0; man_gnt = 1'b0; auto_gnt = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        step();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstN = 1'b0;
        #1;
        n_checks++; if (rd_addr !== 5'd1) begin n_fail++; $display("FAIL reset_rd_addr got %0d exp 1", rd_addr); end
        n_checks++; if (wb_req !== 1'b0) begin n_fail++; $display("FAIL reset_wb_req got %b exp 0", wb_req); end
        n_checks++; if ({wb_addr, wb_data, wb_parity} !== 52'd0) begin n_fail++; $display("FAIL reset_wb_payload got %h exp 0", {wb_addr, wb_data, wb_parity}); end
        n_checks++; if ({corr_count, uncorr_count} !== '0) begin n_fail++; $display("FAIL reset_counts got %h exp 0", {corr_count, uncorr_count}); end
        n_checks++; if ({uncorr_flag, uncorr_addr, busy} !== 7'd0) begin n_fail++; $display("FAIL reset_flags got %h exp 0", {uncorr_flag, uncorr_addr, busy}); end
        step();
        rstN = 1'b1;
    endtask

    task automatic test_clean_walk();
        int bc, bw, t;
        logic [4:0] ea;
        do_reset(); init_clean();
        bc = chk_addr.size(); bw = wbreq_cycles;
        scrub_en = 1'b1;
        t = 0;
        while (chk_addr.size() < bc + 32 && t < 400) begin @(negedge clk); t++; end
        n_checks++; if (chk_addr.size() < bc + 32) begin n_fail++; $display("FAIL walk_timeout got %0d checks exp 32", chk_addr.size() - bc); end
        for (int k = 0; k < 32 && bc + k < chk_addr.size(); k++) begin
            ea = (k == 31) ? 5'd1 : 5'(k + 1);
            n_checks++; if (chk_addr[bc+k] !== ea) begin n_fail++; $display("FAIL walk_addr[%0d] got %0d exp %0d", k, chk_addr[bc+k], ea); end
            if (k > 0) begin
                n_checks++; if (chk_cyc[bc+k] - chk_cyc[bc+k-1] != 6) begin n_fail++; $display("FAIL walk_spacing[%0d] got %0d exp 6", k, chk_cyc[bc+k] - chk_cyc[bc+k-1]); end
            end
        end
        scrub_en = 1'b0;
        n_checks++; if (wbreq_cycles != bw) begin n_fail++; $display("FAIL walk_no_wb got %0d req cycles exp 0", wbreq_cycles - bw); end
        n_checks++; if ({corr_count, uncorr_count} !== '0) begin n_fail++; $display("FAIL walk_counts got %h exp 0", {corr_count, uncorr_count}); end
    endtask

    task automatic test_data_error_delayed_grant();
        int bw, bo, t;
        logic [51:0] e;
        do_reset(); init_clean();
        mem_d[5] = 32'hDEADBEEF ^ 32'h80;
        mem_p[5] = enc(32'hDEADBEEF);
        exp_wb.push_back({5'd5, 32'hDEADBEEF, enc(32'hDEADBEEF)});
        bw = wbreq_cycles; bo = obs_wb.size();
        scrub_en = 1'b1;
        t = 0;
        while (!wb_req && t < 100) begin @(negedge clk); t++; end
        n_checks++; if (wb_req !== 1'b1) begin n_fail++; $display("FAIL data_wb_req_timeout got %b exp 1", wb_req); end
        n_checks++; if (wb_addr !== 5'd5) begin n_fail++; $display("FAIL data_wb_addr got %0d exp 5", wb_addr); end
        n_checks++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL data_wb_data got %h exp deadbeef", wb_data); end
        n_checks++; if (wb_parity !== enc(32'hDEADBEEF)) begin n_fail++; $display("FAIL data_wb_parity got %h exp %h", wb_parity, enc(32'hDEADBEEF)); end
        step();
        @(negedge clk);
        n_checks++; if ({wb_req, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_fail++; $display("FAIL data_hold got %h exp %h", {wb_req, wb_addr, wb_data}, {1'b1, 5'd5, 32'hDEADBEEF}); end
        step(); man_gnt = 1'b1;
        step(); man_gnt = 1'b0;
        @(negedge clk);
        n_checks++; if (wb_req !== 1'b0) begin n_fail++; $display("FAIL data_req_drop got %b exp 0", wb_req); end
        scrub_en = 1'b0;
        n_checks++; if (wbreq_cycles - bw != 3) begin n_fail++; $display("FAIL data_req_cycles got %0d exp 3", wbreq_cycles - bw); end
        n_checks++; if (obs_wb.size() - bo != 1) begin n_fail++; $display("FAIL data_write_count got %0d exp 1", obs_wb.size() - bo); end
        e = exp_wb.pop_front();
        if (obs_wb.size() > bo) begin
            n_checks++; if (obs_wb[bo] !== e) begin n_fail++; $display("FAIL data_write got %h exp %h", obs_wb[bo], e); end
        end
        n_checks++; if (corr_count !== 16'd1) begin n_fail++; $display("FAIL data_corr_count got %0d exp 1", corr_count); end
    endtask

    task automatic test_parity_error();
        int bo, t;
        logic [31:0] d;
        logic [51:0] e;
        do_reset(); init_clean();
        d = $urandom;
        mem_d[3] = d;
        mem_p[3] = enc(d) ^ 15'h8;
        exp_wb.push_back({5'd3, d, enc(d)});
        bo = obs_wb.size();
        auto_gnt = 1'b1; scrub_en = 1'b1;
        t = 0;
        while (obs_wb.size() <= bo && t < 100) begin @(negedge clk); t++; end
        scrub_en = 1'b0;
        e = exp_wb.pop_front();
        n_checks++; if (obs_wb.size() <= bo) begin n_fail++; $display("FAIL parity_write_timeout got 0 writes exp 1"); end
        else begin
            n_checks++; if (obs_wb[bo] !== e) begin n_fail++; $display("FAIL parity_write got %h exp %h", obs_wb[bo], e); end
        end
        n_checks++; if ({corr_count, uncorr_count} !== {16'd1, 16'd0}) begin n_fail++; $display("FAIL parity_counts got %h exp 00010000", {corr_count, uncorr_count}); end
    endtask

    task automatic test_double_error();
        int bc, bw, t;
        logic [31:0] d;
        do_reset(); init_clean();
        d = $urandom;
        mem_d[9] = d ^ 32'h0010_0001;
        mem_p[9] = enc(d);
        bc = chk_addr.size(); bw = wbreq_cycles;
        scrub_en = 1'b1;
        t = 0;
        while (!uncorr_flag && t < 150) begin @(negedge clk); t++; end
        n_checks++; if (uncorr_flag !== 1'b1) begin n_fail++; $display("FAIL dbl_flag got %b exp 1", uncorr_flag); end
        n_checks++; if (uncorr_count !== 16'd1) begin n_fail++; $display("FAIL dbl_count got %0d exp 1", uncorr_count); end
        n_checks++; if (uncorr_addr !== 5'd9) begin n_fail++; $display("FAIL dbl_addr got %0d exp 9", uncorr_addr); end
        t = 0;
        while (chk_addr.size() < bc + 10 && t < 30) begin @(negedge clk); t++; end
        scrub_en = 1'b0;
        n_checks++; if (chk_addr.size() < bc + 10) begin n_fail++; $display("FAIL dbl_next_timeout got %0d checks exp 10", chk_addr.size() - bc); end
        else begin
            n_checks++; if (chk_addr[bc+9] !== 5'd10) begin n_fail++; $display("FAIL dbl_next_addr got %0d exp 10", chk_addr[bc+9]); end
        end
        n_checks++; if (wbreq_cycles != bw) begin n_fail++; $display("FAIL dbl_no_wb got %0d req cycles exp 0", wbreq_cycles - bw); end
        n_checks++; if (corr_count !== 16'd0) begin n_fail++; $display("FAIL dbl_corr got %0d exp 0", corr_count); end
    endtask

    task automatic test_conflict_cancel();
        int bc, bo, t;
        do_reset(); init_clean();
        mem_d[12] = mem_d[12] ^ 32'h8000_0000;
        bc = chk_addr.size(); bo = obs_wb.size();
        scrub_en = 1'b1;
        t = 0;
        while (!wb_req && t < 150) begin @(negedge clk); t++; end
        n_checks++; if (wb_req !== 1'b1 || wb_addr !== 5'd12) begin n_fail++; $display("FAIL cfl_wb_req got %b/%0d exp 1/12", wb_req, wb_addr); end
        step(); cpu_we = 1'b1; cpu_waddr = 5'd12;
        step(); cpu_we = 1'b0;
        @(negedge clk);
        n_checks++; if (wb_req !== 1'b0) begin n_fail++; $display("FAIL cfl_req_drop got %b exp 0", wb_req); end
        t = 0;
        while (chk_addr.size() < bc + 13 && t < 30) begin @(negedge clk); t++; end
        scrub_en = 1'b0;
        n_checks++; if (chk_addr.size() < bc + 13) begin n_fail++; $display("FAIL cfl_next_timeout got %0d checks exp 13", chk_addr.size() - bc); end
        else begin
            n_checks++; if (chk_addr[bc+12] !== 5'd13) begin n_fail++; $display("FAIL cfl_next_addr got %0d exp 13", chk_addr[bc+12]); end
        end
        n_checks++; if (obs_wb.size() != bo) begin n_fail++; $display("FAIL cfl_no_write got %0d writes exp 0", obs_wb.size() - bo); end
        n_checks++; if (corr_count !== 16'd1) begin n_fail++; $display("FAIL cfl_corr got %0d exp 1", corr_count); end
    endtask

    task automatic test_reset_mid_wb();
        int t;
        do_reset(); init_clean();
        mem_d[2] = mem_d[2] ^ 32'h0000_0400;
        scrub_en = 1'b1;
        t = 0;
        while (!wb_req && t < 100) begin @(negedge clk); t++; end
        n_checks++; if (wb_req !== 1'b1 || corr_count !== 16'd1) begin n_fail++; $display("FAIL rstwb_pre got %b/%0d exp 1/1", wb_req, corr_count); end
        #2 rstN = 1'b0;
        #1;
        n_checks++; if (wb_req !== 1'b0) begin n_fail++; $display("FAIL rstwb_req got %b exp 0", wb_req); end
        n_checks++; if (corr_count !== 16'd0) begin n_fail++; $display("FAIL rstwb_corr got %0d exp 0", corr_count); end
        n_checks++; if ({rd_addr, busy} !== {5'd1, 1'b0}) begin n_fail++; $display("FAIL rstwb_addr_busy got %h exp %h", {rd_addr, busy}, {5'd1, 1'b0}); end
        scrub_en = 1'b0;
        step();
        rstN = 1'b1;
    endtask

    task automatic test_clear_vs_inc();
        int bo, t;
        logic [51:0] e;
        do_reset(); init_clean();
        mem_d[1] = mem_d[1] ^ 32'h1;
        mem_d[2] = mem_d[2] ^ 32'h2;
        exp_wb.push_back({5'd1, mem_d[1] ^ 32'h1, mem_p[1]});
        exp_wb.push_back({5'd2, mem_d[2] ^ 32'h2, mem_p[2]});
        bo = obs_wb.size();
        auto_gnt = 1'b1; scrub_en = 1'b1;
        t = 0;
        while (!(busy && rd_addr == 5'd2) && t < 100) begin @(negedge clk); t++; end
        n_checks++; if (corr_count !== 16'd1) begin n_fail++; $display("FAIL clr_pre_corr got %0d exp 1", corr_count); end
        step(); clear_stats = 1'b1;
        step(); clear_stats = 1'b0;
        @(negedge clk);
        n_checks++; if (corr_count !== 16'd0) begin n_fail++; $display("FAIL clr_same_cycle got %0d exp 0", corr_count); end
        t = 0;
        while (obs_wb.size() < bo + 2 && t < 50) begin @(negedge clk); t++; end
        scrub_en = 1'b0;
        n_checks++; if (obs_wb.size() < bo + 2) begin n_fail++; $display("FAIL clr_write_timeout got %0d writes exp 2", obs_wb.size() - bo); end
        for (int k = 0; k < 2; k++) begin
            e = exp_wb.pop_front();
            if (obs_wb.size() > bo + k) begin
                n_checks++; if (obs_wb[bo+k] !== e) begin n_fail++; $display("FAIL clr_write[%0d] got %h exp %h", k, obs_wb[bo+k], e); end
            end
        end
    endtask

    initial begin
        build_cols();
        init_clean();
        test_reset();
        test_clean_walk();
        test_data_error_delayed_grant();
        test_parity_error();
        test_double_error();
        test_conflict_cancel();
        test_reset_mid_wb();
        test_clear_vs_inc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_reg_scrubber.md
Name: ecc_reg_scrubber

Overview:
Background scrubber for the SEC-DED protected register file. It walks register addresses, reads data and stored parity through a dedicated scrub read port, and checks them with the existing decoder (top_decoder). Single-bit errors in data or parity are rewritten with corrected data and freshly encoded parity (top_encoder) through an arbitrated write port. Double errors are counted and flagged; no write is made for them.

Parameters:
INTERVAL, 1024, idle cycles between successive register checks (>=1)
FIRST_ADDR, 1, first scrubbed address (x0 excluded)
LAST_ADDR, 31, last scrubbed address; wraps to FIRST_ADDR
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
rstN  in  1  asynchronous active-low reset
scrub_en  in  1  enables scrubbing
clear_stats  in  1  synchronous clear of counters and sticky flag
rd_addr  out  5  scrub read address into data and ECC storage
rd_data  in  32  raw data at rd_addr (combinational read)
rd_parity  in  15  raw stored parity at rd_addr
cpu_we  in  1  core register-file write enable
cpu_waddr  in  5  core register-file write address
wb_req  out  1  writeback request
wb_gnt  in  1  writeback grant; the write occurs in the cycle where wb_req&wb_gnt
wb_addr  out  5  writeback address
wb_data  out  32  corrected data
wb_parity  out  15  encoded parity of wb_data
corr_count  out  CNT_W  corrected-error count, saturating
uncorr_count  out  CNT_W  uncorrectable-error count, saturating
uncorr_flag  out  1  sticky uncorrectable indicator
uncorr_addr  out  5  address of most recent uncorrectable error
busy  out  1  high in READ, CHECK and WB

Behaviour:
- Clock clk. Reset rstN is asynchronous and active-low. Reset state: IDLE, rd_addr=FIRST_ADDR, interval counter=INTERVAL-1, wb_req=0, wb_addr/wb_data/wb_parity=0, counters=0, uncorr_flag=0, uncorr_addr=0, busy=0.
- States: IDLE, WAIT, READ, CHECK, WB.
- IDLE: if scrub_en=1, go to WAIT with the counter reloaded.
- WAIT: the counter decrements each cycle. At 0 go to READ. WAIT lasts exactly INTERVAL cycles.
- READ (1 cycle): rd_addr is stable. rd_data and rd_parity are registered into capture registers at the end of the cycle.
- CHECK (1 cycle): the decoder runs on the captured values. enc = encode(corrected).
  - Double error: uncorr_count++ (sat), uncorr_flag<=1, uncorr_addr<=addr. Advance the address, go to WAIT.
  - Single error (corrected != raw data, or enc != raw parity): corr_count++ (sat). Load wb_addr/wb_data/wb_parity, assert wb_req next cycle, go to WB.
  - Clean: advance the address, go to WAIT.
- WB: hold wb_req and the payload stable until wb_gnt. On grant: wb_req drops next cycle, advance the address, go to WAIT.
- Conflict cancel: if cpu_we=1 and cpu_waddr=current addr in any READ, CHECK or WB cycle (the grant cycle included), the writeback is cancelled. No write is made (wb_req stays or returns to 0 next cycle), the address advances, and the state goes to WAIT. A correction already counted stays counted.
- Address advance: addr==LAST_ADDR -> FIRST_ADDR, otherwise addr+1.
- scrub_en=0 in any non-IDLE state: go to IDLE next cycle. Any pending writeback is dropped. rd_addr is kept, so scrubbing resumes at the same address.
- Counters saturate at all-ones.
- clear_stats zeroes both counters, uncorr_flag and uncorr_addr. It wins over a same-cycle increment.
- Reset mid-operation: everything returns to reset values immediately. wb_req goes low asynchronously.

Test Plan:
1. INTERVAL=4, all registers clean, scrub_en=1 -> rd_addr sequence 1,2,...,31,1 with one step per 6 cycles; wb_req never 1; both counts 0.
2. x5=0xDEADBEEF with data bit 7 flipped, wb_gnt delayed 3 cycles -> wb_req held 3 cycles; wb_addr=5, wb_data=0xDEADBEEF, wb_parity=encode(0xDEADBEEF); exactly one granted write; corr_count=1.
3. x3 stored parity bit 3 flipped, data intact -> writeback of unchanged data with corrected parity; corr_count=1.
4. x9 with data bits 0 and 20 flipped -> no wb_req; uncorr_count=1, uncorr_flag=1, uncorr_addr=9; next address checked is 10.
5. x12 single-bit error, cpu_we=1 with cpu_waddr=12 during WB -> wb_req low next cycle, no write, corr_count=1, scan continues at 13.
6. rstN pulsed low during WB -> wb_req=0 immediately, counts 0, rd_addr=1. Separately, clear_stats in the same cycle as a corr increment -> corr_count=0.
